contador_gray_param: RTL
========================

Name: contador_gray_param

Overview:
- Parametrised up/down Gray-code counter; next generation of the fixed-width enable-only Gray counter.
- Adds width, up/down, synchronous load, wrap-or-saturate mode, terminal flags and an overflow pulse.
- Outputs the count in Gray and binary form; both come from the same register edge.
- Used as a pointer/sequence source and checked against its synthesised netlist by the standard comparison bench (error = outputs differ).

Parameters:
WIDTH, 4, counter width in bits (>=2); MAX = 2^WIDTH-1.
SATURATE, 0, 0 = wrap at the ends; 1 = hold at MAX (up) or 0 (down).
RESET_VAL, 0, binary count loaded by reset (must be <= MAX).

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-low reset.
enable  input  1  count one step this cycle when high.
up_down  input  1  1 = increment, 0 = decrement.
load  input  1  synchronous load, priority over enable.
load_value  input  WIDTH  binary value taken on load.
salida_gray  output  WIDTH  registered Gray code of count.
salida_bin  output  WIDTH  registered binary count.
tc_max  output  1  registered, 1 when count == MAX.
tc_min  output  1  registered, 1 when count == 0.
desborde  output  1  registered one-cycle pulse on wrap.

Behaviour:
- Interface fixed: one clock, clk; reset asynchronous and active-low, port reset.
- reset low, immediate and independent of clk:
  - salida_bin = RESET_VAL; salida_gray = RESET_VAL ^ (RESET_VAL >> 1).
  - tc_max and tc_min reflect RESET_VAL; desborde = 0.
  - Holds while low; counting resumes on the first rising edge after reset goes high.
- Internal state: one WIDTH-bit binary register. Gray = bin ^ (bin >> 1), computed from the next binary value and registered on the same edge as bin. No cycle where the two outputs disagree.
- Latency: an input sampled on edge N appears on all outputs after edge N; one cycle, no combinational input-to-output path.
- Priority per edge: load > enable > hold.
  - load = 1: bin <= load_value regardless of enable and up_down; desborde <= 0.
  - enable = 1, up_down = 1: bin <= bin + 1.
  - enable = 1, up_down = 0: bin <= bin - 1.
  - enable = 0 and load = 0: all outputs hold; desborde <= 0.
- Wrap boundaries:
  - SATURATE = 0: MAX+1 wraps to 0 and 0-1 wraps to MAX; desborde = 1 for exactly the cycle after the wrapping edge.
  - SATURATE = 1: count holds at MAX (up) or 0 (down); desborde stays 0.
- Flags: tc_max = (next bin == MAX) and tc_min = (next bin == 0), registered alongside the count. Never both 1 (WIDTH >= 2).
- Gray property: every enabled non-load step changes exactly one bit of salida_gray, including the MAX<->0 wrap. A saturated hold changes none. A load may change any number of bits.
- Direction change between consecutive cycles needs no idle cycle.
- Reset asserted mid-count discards the count and any pending load.

Test Plan (WIDTH=4, SATURATE=0, RESET_VAL=0 unless noted):
1. Reset: hold reset=0 for 3 cycles, then release; enable=1, up_down=1 for 16 cycles. Required:
   - salida_gray sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
   - tc_max = 1 at gray 8 (bin 15); desborde = 1 on the cycle after 8 -> 0.
2. Hold and resume: enable=0 for 3 cycles mid-count at bin 5 -> all outputs hold at 5 / gray 7. Re-enable -> bin 6, gray 5 on the next edge.
3. Down count and wrap: up_down=0 from bin 1 -> 0 (tc_min = 1), then 15 (gray 8, tc_max = 1, desborde = 1).
4. Load: load=1, load_value=9, enable=1 on the same edge -> bin 9, gray D, no increment, desborde = 0. Next enabled up step -> bin A, gray F.
5. Saturate (SATURATE=1, RESET_VAL=14): enable=1, up_down=1 -> bin 15, then holds at 15 with desborde = 0. up_down=0 -> bin 14 next edge.
6. Asynchronous reset mid-count: drop reset between clock edges at bin 11 -> outputs go to 0 immediately, before the next edge. In parallel, a synthesised netlist instance is compared against RTL throughout; the error signal must stay 0.

Source files
------------

// File: rtl/contador_gray_param.sv
// Parametrised up/down Gray counter: one binary register, Gray/flags registered from the next value.
// Load takes priority over enable; the ends either wrap with a one-cycle desborde pulse or saturate.
module contador_gray_param #(
    parameter int WIDTH     = 4,
    parameter int SATURATE  = 0,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] salida_gray,
    output logic [WIDTH-1:0] salida_bin,
    output logic             tc_max,
    output logic             tc_min,
    output logic             desborde
);

    localparam logic [WIDTH-1:0] MAX      = '1;
    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_tc_max;
    logic             r_tc_min;
    logic             r_desborde;

    logic [WIDTH-1:0] w_next_bin;
    logic             w_wrap;

    always_comb begin
        w_next_bin = r_bin;
        w_wrap     = 1'b0;
        if (load) begin
            w_next_bin = load_value;
        end else if (enable) begin
            if (up_down) begin
                if (r_bin == MAX) begin
                    // At an end the count either saturates in place or wraps and flags it
                    if (SATURATE != 0) begin
                        w_next_bin = MAX;
                    end else begin
                        w_next_bin = '0;
                        w_wrap     = 1'b1;
                    end
                end else begin
                    w_next_bin = r_bin + 1'b1;
                end
            end else begin
                if (r_bin == '0) begin
                    if (SATURATE != 0) begin
                        w_next_bin = '0;
                    end else begin
                        w_next_bin = MAX;
                        w_wrap     = 1'b1;
                    end
                end else begin
                    w_next_bin = r_bin - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bin      <= RST_BIN;
            r_gray     <= RST_GRAY;
            r_tc_max   <= (RST_BIN == MAX);
            r_tc_min   <= (RST_BIN == '0);
            r_desborde <= 1'b0;
        end else begin
            r_bin      <= w_next_bin;
            r_gray     <= w_next_bin ^ (w_next_bin >> 1);
            r_tc_max   <= (w_next_bin == MAX);
            r_tc_min   <= (w_next_bin == '0);
            r_desborde <= w_wrap;
        end
    end

    assign salida_bin  = r_bin;
    assign salida_gray = r_gray;
    assign tc_max      = r_tc_max;
    assign tc_min      = r_tc_min;
    assign desborde    = r_desborde;

endmodule
